// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, responder FSM states
// and the funct3 legality check.
package rv32i_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} mem_state_t;

   // Stores allow only B/H/W; loads also allow the unsigned byte/half forms.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic sized;
      sized = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (is_store) return sized;
      return sized || (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/data_ram_be.sv
// Single-port-style word RAM with independent read/write addresses,
// per-byte write enables and a registered read. Storage has no reset.
module data_ram_be #(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic                           iClk,
   input  logic                           we,
   input  logic [3:0]                     be,
   input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
   input  logic [31:0]                    wdata,
   input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge iClk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/data_mem_resp.sv
// RV32I data-memory responder: one load/store per handshake, byte-lane writes,
// sign/zero-extended reads, misalign/illegal flagging. Response two cycles after accept.
module data_mem_resp
   import rv32i_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iReq_Valid,
   output logic        oReq_Ready,
   input  logic        iData_WrEn,
   input  logic [2:0]  iFunct3,
   input  logic [31:0] iAddr,
   input  logic [31:0] iWData,
   output logic        oResp_Valid,
   output logic [31:0] oRData,
   output logic        oMisalign,
   output logic        oIllegal
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   mem_state_t      state;
   logic            req_store;
   logic [2:0]      req_f3;
   logic [AW+1:0]   req_addr;
   logic [31:0]     req_wdata;

   logic [1:0]      lane;
   logic            illegal;
   logic            misalign;
   logic            ram_we;
   logic [3:0]      be;
   logic [31:0]     ram_wdata;
   logic [31:0]     ram_rdata;
   logic [AW-1:0]   raddr;
   logic [7:0]      rbyte;
   logic [15:0]     rhalf;
   logic [31:0]     load_data;

   // Address bits above the RAM depth are ignored so accesses wrap.
   logic unused_addr;
   assign unused_addr = ^iAddr[31:AW+2];

   // Lane/enable generation, error flags and load extension from the captured request.
   always_comb begin
      lane      = req_addr[1:0];
      illegal   = !f3_legal(req_store, req_f3);
      misalign  = 1'b0;
      be        = 4'b0000;
      ram_wdata = req_wdata;
      case (req_f3[1:0])
         2'b00: begin
            be        = 4'(4'b0001 << lane);
            ram_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            misalign  = lane[0];
            be        = lane[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            misalign  = (lane != 2'b00);
            be        = 4'b1111;
         end
         default: ;
      endcase
      misalign = misalign && !illegal;
      ram_we   = (state == ST_ACCESS) && req_store && !illegal && !misalign;

      // The read is launched while still in IDLE so data is ready during ACCESS.
      raddr = (state == ST_IDLE) ? iAddr[AW+1:2] : req_addr[AW+1:2];

      rbyte = ram_rdata[{lane, 3'b000} +: 8];
      rhalf = lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      case (req_f3)
         F3_B:    load_data = {{24{rbyte[7]}}, rbyte};
         F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
         F3_W:    load_data = ram_rdata;
         F3_BU:   load_data = {24'h000000, rbyte};
         F3_HU:   load_data = {16'h0000, rhalf};
         default: load_data = 32'h0000_0000;
      endcase
   end

   data_ram_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .iClk  (iClk),
      .we    (ram_we),
      .be    (be),
      .waddr (req_addr[AW+1:2]),
      .wdata (ram_wdata),
      .raddr (raddr),
      .rdata (ram_rdata)
   );

   // IDLE -> ACCESS -> RESP -> IDLE with request capture and registered response.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state       <= ST_IDLE;
         oReq_Ready  <= 1'b1;
         oResp_Valid <= 1'b0;
         oRData      <= 32'h0000_0000;
         oMisalign   <= 1'b0;
         oIllegal    <= 1'b0;
         req_store   <= 1'b0;
         req_f3      <= 3'b000;
         req_addr    <= '0;
         req_wdata   <= 32'h0000_0000;
      end else begin
         oResp_Valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (iReq_Valid) begin
                  req_store  <= iData_WrEn;
                  req_f3     <= iFunct3;
                  req_addr   <= iAddr[AW+1:0];
                  req_wdata  <= iWData;
                  oReq_Ready <= 1'b0;
                  state      <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               oResp_Valid <= 1'b1;
               oRData      <= (req_store || illegal || misalign) ? 32'h0000_0000 : load_data;
               oMisalign   <= misalign;
               oIllegal    <= illegal;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               oRData     <= 32'h0000_0000;
               oMisalign  <= 1'b0;
               oIllegal   <= 1'b0;
               oReq_Ready <= 1'b1;
               state      <= ST_IDLE;
            end
            default: begin
               oReq_Ready <= 1'b1;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed self-checking bench for data_mem_resp: store/load lanes, extension,
// error flags, address wrap, reset during ACCESS and back-to-back throughput.
module tb_data_mem_resp;

   logic        iClk = 1'b0;
   logic        iRst;
   logic        iReq_Valid;
   logic        oReq_Ready;
   logic        iData_WrEn;
   logic [2:0]  iFunct3;
   logic [31:0] iAddr;
   logic [31:0] iWData;
   logic        oResp_Valid;
   logic [31:0] oRData;
   logic        oMisalign;
   logic        oIllegal;

   int checks = 0;
   int failures = 0;

   data_mem_resp #(.DEPTH_WORDS(256)) dut (
      .iClk        (iClk),
      .iRst        (iRst),
      .iReq_Valid  (iReq_Valid),
      .oReq_Ready  (oReq_Ready),
      .iData_WrEn  (iData_WrEn),
      .iFunct3     (iFunct3),
      .iAddr       (iAddr),
      .iWData      (iWData),
      .oResp_Valid (oResp_Valid),
      .oRData      (oRData),
      .oMisalign   (oMisalign),
      .oIllegal    (oIllegal)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One full handshake; expects the response strobe on the second negedge after accept.
   task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_mis, input logic exp_ill);
      int w;
      int lat;
      @(negedge iClk);
      iReq_Valid = 1'b1;
      iData_WrEn = st;
      iFunct3    = f3;
      iAddr      = addr;
      iWData     = wd;
      w = 0;
      while (!oReq_Ready && w < 8) begin
         @(negedge iClk);
         w++;
      end
      check({tag, ".ready"}, 32'(w < 8), 32'd1);
      @(negedge iClk);
      iReq_Valid = 1'b0;
      lat = 0;
      while (!oResp_Valid && lat < 8) begin
         @(negedge iClk);
         lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'd1);
      check({tag, ".rdata"}, oRData, exp_rd);
      check({tag, ".mis"}, 32'(oMisalign), 32'(exp_mis));
      check({tag, ".ill"}, 32'(oIllegal), 32'(exp_ill));
   endtask

   initial begin
      int acc;
      int resp;
      logic [31:0] last;
      iRst = 1'b1;
      iReq_Valid = 1'b0;
      iData_WrEn = 1'b0;
      iFunct3 = 3'b000;
      iAddr = 32'h0;
      iWData = 32'h0;
      repeat (3) @(negedge iClk);
      iRst = 1'b0;
      @(negedge iClk);
      check("rst.ready", 32'(oReq_Ready), 32'd1);
      check("rst.valid", 32'(oResp_Valid), 32'd0);
      check("rst.rdata", oRData, 32'h0);
      check("rst.mis", 32'(oMisalign), 32'd0);
      check("rst.ill", 32'(oIllegal), 32'd0);

      // Word store/load
      txn("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
      txn("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
      // Byte store into lane 3, signed/unsigned reads, neighbours intact
      txn("sb13", 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, 1'b0);
      txn("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b0);
      txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 1'b0, 1'b0);
      txn("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b0);
      txn("lb10", 1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 1'b0);
      // Upper-address bits ignored: 0x410 aliases 0x10
      txn("lwwrap", 1'b0, 3'b010, 32'h0000_0410, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b0);
      // Half store into upper half
      txn("sw20", 1'b1, 3'b010, 32'h20, 32'h00000000, 32'h0, 1'b0, 1'b0);
      txn("sh22", 1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0, 1'b0, 1'b0);
      txn("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
      txn("lhu22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0, 1'b0);
      txn("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h80010000, 1'b0, 1'b0);
      // Misaligned accesses
      txn("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 1'b0);
      txn("lh21", 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1, 1'b0);
      txn("sh23", 1'b1, 3'b001, 32'h23, 32'h0000FFFF, 32'h0, 1'b1, 1'b0);
      txn("lw20m", 1'b0, 3'b010, 32'h20, 32'h0, 32'h80010000, 1'b0, 1'b0);
      // Illegal funct3, illegal overrides misalign
      txn("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1);
      txn("ld111m", 1'b0, 3'b111, 32'h11, 32'h0, 32'h0, 1'b0, 1'b1);
      txn("st100", 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
      txn("lw20i", 1'b0, 3'b010, 32'h20, 32'h0, 32'h80010000, 1'b0, 1'b0);

      // Reset during ACCESS of a store drops the write and the response
      txn("sw40", 1'b1, 3'b010, 32'h40, 32'h11111111, 32'h0, 1'b0, 1'b0);
      @(negedge iClk);
      iReq_Valid = 1'b1;
      iData_WrEn = 1'b1;
      iFunct3 = 3'b010;
      iAddr = 32'h40;
      iWData = 32'h12345678;
      @(posedge iClk);
      #2;
      iReq_Valid = 1'b0;
      iRst = 1'b1;
      #2;
      iRst = 1'b0;
      @(negedge iClk);
      check("rstmid.ready", 32'(oReq_Ready), 32'd1);
      resp = 0;
      for (int i = 0; i < 4; i++) begin
         if (oResp_Valid) resp++;
         @(negedge iClk);
      end
      check("rstmid.noresp", 32'(resp), 32'd0);
      txn("lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h11111111, 1'b0, 1'b0);

      // Held request: one accept every three clocks
      @(negedge iClk);
      iReq_Valid = 1'b1;
      iData_WrEn = 1'b0;
      iFunct3 = 3'b010;
      iAddr = 32'h10;
      acc = 0;
      resp = 0;
      last = 32'h0;
      for (int i = 0; i < 9; i++) begin
         if (oReq_Ready) acc++;
         if (oResp_Valid) begin
            resp++;
            last = oRData;
         end
         @(negedge iClk);
      end
      iReq_Valid = 1'b0;
      check("b2b.accepts", 32'(acc), 32'd3);
      check("b2b.resps", 32'(resp), 32'd3);
      check("b2b.rdata", last, 32'hA5ADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
